pin_lock_ctrl: RTL and testbench

Parametrised keypad door-lock controller. Accepts decoded digit strokes and confirm/program requests. Compares the entry against a programmable stored PIN and drives the lock output. Adds three things the fixed-code lock lacks: variable PIN length, PIN reprogramming while unlocked, and failed-attempt lockout with timed auto-relock. Sits between the keypad encoder and the lock actuator.

---
 rtl/pin_lock_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_pin_lock_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_lock_ctrl.sv
// rtl/pin_lock_ctrl.sv - keypad PIN lock controller; DOORLOCK_MASTER_CODE_EN adds a master unlock code
module pin_lock_ctrl #(
    parameter int                              DIGIT_W     = 4,
    parameter int                              MAX_DIGITS  = 8,
    parameter int                              MIN_DIGITS  = 4,
    parameter logic [DIGIT_W*MAX_DIGITS-1:0]   DEFAULT_PIN = 'h4321,
    parameter int                              DEFAULT_LEN = 4,
    parameter int                              MAX_FAILS   = 3,
    parameter int                              UNLOCK_CYC  = 500,
    parameter int                              LOCKOUT_CYC = 1000,
    parameter logic [DIGIT_W*MAX_DIGITS-1:0]   MASTER_PIN  = 'hDADAEFEF
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               key_valid,
    input  logic [DIGIT_W-1:0]                 key_digit,
    input  logic                               confirm,
    input  logic                               program_req,
    output logic                               locked,
    output logic                               lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    entry_len,
    output logic                               unlock_pulse,
    output logic                               fail_pulse,
    output logic                               prog_ok,
    output logic                               prog_err
);

    localparam int LEN_W   = $clog2(MAX_DIGITS + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        ST_LOCKED,
        ST_ENTRY,
        ST_UNLOCKED,
        ST_PROG,
        ST_LOCKOUT
    } state_t;

    typedef logic [MAX_DIGITS-1:0][DIGIT_W-1:0] digits_t;

    state_t              state_q, state_d;
    digits_t             buf_q, buf_d, app_buf;
    logic [LEN_W-1:0]    len_q, len_d, app_len;
    logic                ov_q, ov_d, app_ov;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
    digits_t             pin_q, pin_d;
    logic [LEN_W-1:0]    pin_len_q, pin_len_d;
    logic                locked_q, locked_d, lockout_q, lockout_d;
    logic                unlock_q, fail_p_q, pok_q, perr_q;
    logic                ev_unlock, ev_fail, ev_pok, ev_perr;
    logic                key_ok, pin_hit, prog_fit, tmr_exp, entry_hit;

`ifdef DOORLOCK_MASTER_CODE_EN
    logic                master_hit;

    // Master code contains hex digits, so every strobed key is accepted in this build
    assign key_ok     = key_valid;
    assign master_hit = !app_ov && (app_len == LEN_W'(MAX_DIGITS)) && (app_buf == MASTER_PIN);
    assign entry_hit  = pin_hit || master_hit;
`else
    logic                unused_master;

    assign key_ok        = key_valid && (key_digit <= DIGIT_W'(9));
    assign entry_hit     = pin_hit;
    assign unused_master = ^MASTER_PIN;
`endif

    assign tmr_exp  = (tmr_q == TMR_W'(1));
    assign fail_inc = (fail_q == FAIL_W'(MAX_FAILS)) ? fail_q : fail_q + FAIL_W'(1);
    assign prog_fit = !app_ov && (app_len >= LEN_W'(MIN_DIGITS));

    // Buffer as it would look with this cycle's key appended (key precedes a same-cycle confirm)
    always_comb begin
        app_buf = buf_q;
        app_len = len_q;
        app_ov  = ov_q;
        if (key_ok) begin
            if (len_q == LEN_W'(MAX_DIGITS)) begin
                app_ov = 1'b1;
            end else begin
                for (int i = 0; i < MAX_DIGITS; i++) begin
                    if (len_q == LEN_W'(i)) app_buf[i] = key_digit;
                end
                app_len = len_q + LEN_W'(1);
            end
        end
    end

    // Compare the appended buffer with the stored PIN over the stored length only
    always_comb begin
        pin_hit = !app_ov && (app_len == pin_len_q);
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((LEN_W'(i) < pin_len_q) && (app_buf[i] != pin_q[i])) pin_hit = 1'b0;
        end
    end

    // State and datapath registers, outputs registered alongside
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_LOCKED;
            buf_q     <= '0;
            len_q     <= '0;
            ov_q      <= 1'b0;
            tmr_q     <= '0;
            fail_q    <= '0;
            pin_q     <= DEFAULT_PIN;
            pin_len_q <= LEN_W'(DEFAULT_LEN);
            locked_q  <= 1'b1;
            lockout_q <= 1'b0;
            unlock_q  <= 1'b0;
            fail_p_q  <= 1'b0;
            pok_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            len_q     <= len_d;
            ov_q      <= ov_d;
            tmr_q     <= tmr_d;
            fail_q    <= fail_d;
            pin_q     <= pin_d;
            pin_len_q <= pin_len_d;
            locked_q  <= locked_d;
            lockout_q <= lockout_d;
            unlock_q  <= ev_unlock;
            fail_p_q  <= ev_fail;
            pok_q     <= ev_pok;
            perr_q    <= ev_perr;
        end
    end

    // Next-state: per-state handling of keys, confirm, program requests and timer expiry
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        len_d     = len_q;
        ov_d      = ov_q;
        tmr_d     = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
        fail_d    = fail_q;
        pin_d     = pin_q;
        pin_len_d = pin_len_q;
        ev_unlock = 1'b0;
        ev_fail   = 1'b0;
        ev_pok    = 1'b0;
        ev_perr   = 1'b0;
        case (state_q)
            ST_LOCKED, ST_ENTRY: begin
                if (key_ok) begin
                    buf_d   = app_buf;
                    len_d   = app_len;
                    ov_d    = app_ov;
                    state_d = ST_ENTRY;
                end
                // An empty buffer in LOCKED means there is nothing to judge
                if (confirm && (state_q == ST_ENTRY || key_ok)) begin
                    buf_d = '0;
                    len_d = '0;
                    ov_d  = 1'b0;
                    if (entry_hit) begin
                        state_d   = ST_UNLOCKED;
                        fail_d    = '0;
                        tmr_d     = TMR_W'(UNLOCK_CYC);
                        ev_unlock = 1'b1;
                    end else begin
                        ev_fail = 1'b1;
                        fail_d  = fail_inc;
                        if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                            state_d = ST_LOCKOUT;
                            tmr_d   = TMR_W'(LOCKOUT_CYC);
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                if (confirm) begin
                    state_d = ST_LOCKED;
                end else if (program_req) begin
                    state_d = ST_PROG;
                    buf_d   = '0;
                    len_d   = '0;
                    ov_d    = 1'b0;
                    tmr_d   = TMR_W'(UNLOCK_CYC);
                end else if (tmr_exp) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_PROG: begin
                if (confirm) begin
                    if (prog_fit) begin
                        pin_d     = app_buf;
                        pin_len_d = app_len;
                        ev_pok    = 1'b1;
                    end else begin
                        ev_perr   = 1'b1;
                    end
                    buf_d   = '0;
                    len_d   = '0;
                    ov_d    = 1'b0;
                    state_d = ST_UNLOCKED;
                    tmr_d   = TMR_W'(UNLOCK_CYC);
                end else if (key_ok) begin
                    buf_d = app_buf;
                    len_d = app_len;
                    ov_d  = app_ov;
                    tmr_d = TMR_W'(UNLOCK_CYC);
                end else if (tmr_exp) begin
                    state_d = ST_LOCKED;
                    buf_d   = '0;
                    len_d   = '0;
                    ov_d    = 1'b0;
                end
            end
            ST_LOCKOUT: begin
`ifdef DOORLOCK_MASTER_CODE_EN
                if (confirm && master_hit) begin
                    state_d   = ST_UNLOCKED;
                    fail_d    = '0;
                    tmr_d     = TMR_W'(UNLOCK_CYC);
                    ev_unlock = 1'b1;
                    buf_d     = '0;
                    len_d     = '0;
                    ov_d      = 1'b0;
                end else if (tmr_exp || confirm) begin
                    if (tmr_exp) begin
                        state_d = ST_LOCKED;
                        fail_d  = '0;
                    end
                    buf_d = '0;
                    len_d = '0;
                    ov_d  = 1'b0;
                end else if (key_ok) begin
                    buf_d = app_buf;
                    len_d = app_len;
                    ov_d  = app_ov;
                end
`else
                if (tmr_exp) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                end
`endif
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    // Output decode from the upcoming state so locked/lockout change on the same edge as the state
    always_comb begin
        locked_d  = !((state_d == ST_UNLOCKED) || (state_d == ST_PROG));
        lockout_d = (state_d == ST_LOCKOUT);
    end

    assign locked       = locked_q;
    assign lockout      = lockout_q;
    assign fail_cnt     = fail_q;
    assign entry_len    = len_q;
    assign unlock_pulse = unlock_q;
    assign fail_pulse   = fail_p_q;
    assign prog_ok      = pok_q;
    assign prog_err     = perr_q;

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// tb/tb_pin_lock_ctrl.sv - scoreboard bench for pin_lock_ctrl with a cycle-stamped reference model
module tb_pin_lock_ctrl;
    localparam int U  = 8;
    localparam int L  = 16;
    localparam int MF = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       confirm = 1'b0;
    logic       program_req = 1'b0;
    logic       locked, lockout, unlock_pulse, fail_pulse, prog_ok, prog_err;
    logic [1:0] fail_cnt;
    logic [3:0] entry_len;

    always #5 clk = ~clk;

    pin_lock_ctrl #(.UNLOCK_CYC(U), .LOCKOUT_CYC(L)) dut (
        .clk(clk), .rstn(rstn), .key_valid(key_valid), .key_digit(key_digit),
        .confirm(confirm), .program_req(program_req), .locked(locked), .lockout(lockout),
        .fail_cnt(fail_cnt), .entry_len(entry_len), .unlock_pulse(unlock_pulse),
        .fail_pulse(fail_pulse), .prog_ok(prog_ok), .prog_err(prog_err)
    );

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    // Reference model: door state as flags plus absolute edge numbers at which timed phases end
    int  m_entry[$];
    bit  m_ov;
    int  m_pin[$];
    int  m_fails;
    bit  m_open, m_prog;
    int  m_open_end, m_prog_end, m_lock_end;
    bit  exp_locked, exp_lockout;
    int  exp_fail, exp_len;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void publish();
        exp_locked  = !(m_open || m_prog);
        exp_lockout = (m_lock_end != 0);
        exp_fail    = m_fails;
        exp_len     = m_entry.size();
    endfunction

    function automatic void model_reset();
        m_entry.delete();
        m_ov       = 1'b0;
        m_pin      = '{1, 2, 3, 4};
        m_fails    = 0;
        m_open     = 1'b0;
        m_prog     = 1'b0;
        m_lock_end = 0;
        publish();
    endfunction

    function automatic void push_ev(int e, int kind);
        ev_t x;
        x.cyc  = e;
        x.kind = kind;
        sb.push_back(x);
    endfunction

    function automatic void add_digit(int d);
        if (m_entry.size() == 8) m_ov = 1'b1;
        else m_entry.push_back(d);
    endfunction

    function automatic void clear_entry();
        m_entry.delete();
        m_ov = 1'b0;
    endfunction

    function automatic bit entry_matches();
        if (m_ov || m_entry.size() != m_pin.size()) return 1'b0;
        foreach (m_entry[i]) if (m_entry[i] != m_pin[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Advance the model across the next rising edge; kinds: 0 unlock, 1 fail, 2 prog_ok, 3 prog_err
    function automatic void model_step(bit kv, int kd, bit cf, bit pr);
        int e = cyc + 1;
        bit k = kv && (kd <= 9);
        if (m_lock_end != 0) begin
            if (e == m_lock_end) begin
                m_lock_end = 0;
                m_fails    = 0;
            end
        end else if (m_prog) begin
            if (cf) begin
                if (k) add_digit(kd);
                if (!m_ov && m_entry.size() >= 4) begin
                    m_pin = m_entry;
                    push_ev(e, 2);
                end else begin
                    push_ev(e, 3);
                end
                clear_entry();
                m_prog     = 1'b0;
                m_open     = 1'b1;
                m_open_end = e + U;
            end else if (k) begin
                add_digit(kd);
                m_prog_end = e + U;
            end else if (e == m_prog_end) begin
                m_prog = 1'b0;
                clear_entry();
            end
        end else if (m_open) begin
            if (cf) m_open = 1'b0;
            else if (pr) begin
                m_open     = 1'b0;
                m_prog     = 1'b1;
                m_prog_end = e + U;
                clear_entry();
            end else if (e == m_open_end) m_open = 1'b0;
        end else begin
            if (k) add_digit(kd);
            if (cf && m_entry.size() > 0) begin
                if (entry_matches()) begin
                    m_open     = 1'b1;
                    m_open_end = e + U;
                    m_fails    = 0;
                    push_ev(e, 0);
                end else begin
                    push_ev(e, 1);
                    if (m_fails < MF) m_fails++;
                    if (m_fails == MF) m_lock_end = e + L;
                end
                clear_entry();
            end
        end
        publish();
    endfunction

    task automatic cycle(input bit kv, input int kd, input bit cf, input bit pr);
        @(negedge clk);
        rstn        = 1'b1;
        key_valid   = kv;
        key_digit   = 4'(kd);
        confirm     = cf;
        program_req = pr;
        model_step(kv, kd, cf, pr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic type_code(input logic [35:0] code, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, int'(code[i*4 +: 4]), 1'b0, 1'b0);
    endtask

    task automatic do_confirm();
        cycle(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic do_program();
        cycle(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rstn        = 1'b0;
        key_valid   = 1'b0;
        confirm     = 1'b0;
        program_req = 1'b0;
        model_reset();
    endtask

    task automatic type_model_pin(input bit merge_confirm);
        int p[$];
        p = m_pin;
        for (int i = 0; i < p.size(); i++) begin
            if (merge_confirm && i == p.size() - 1) cycle(1'b1, p[i], 1'b1, 1'b0);
            else cycle(1'b1, p[i], 1'b0, 1'b0);
        end
        if (!merge_confirm) do_confirm();
    endtask

    task automatic type_random(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, int'($urandom_range(0, 9)), 1'b0, 1'b0);
    endtask

    // Monitor: registered outputs sampled just after each rising edge
    initial begin
        logic [3:0] obs;
        ev_t        x;
        forever begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({locked, lockout, fail_cnt, entry_len} !==
                {exp_locked, exp_lockout, 2'(exp_fail), 4'(exp_len)}) begin
                n_fail++;
                $display("FAIL state cyc=%0d actual locked=%0b lockout=%0b fail_cnt=%0d entry_len=%0d required locked=%0b lockout=%0b fail_cnt=%0d entry_len=%0d",
                         cyc, locked, lockout, fail_cnt, entry_len, exp_locked, exp_lockout, exp_fail, exp_len);
            end
            obs = {prog_err, prog_ok, fail_pulse, unlock_pulse};
            if (obs != 4'b0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL pulse cyc=%0d actual pulses=%b required none", cyc, obs);
                end else begin
                    x = sb.pop_front();
                    if (x.cyc != cyc || obs != 4'(1 << x.kind)) begin
                        n_fail++;
                        $display("FAIL pulse cyc=%0d actual pulses=%b required pulses=%b at cyc %0d",
                                 cyc, obs, 4'(1 << x.kind), x.cyc);
                    end
                end
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                x = sb.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_pulse cyc=%0d actual pulses=%b required kind %0d at cyc %0d",
                         cyc, obs, x.kind, x.cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        model_reset();
        repeat (2) @(negedge clk);
        idle(2);

        type_code(36'h4321, 4); do_confirm(); idle(12);

        repeat (3) begin type_code(36'h9999, 4); do_confirm(); idle(1); end
        type_code(36'h4321, 4); do_confirm(); idle(20);
        type_code(36'h4321, 4); do_confirm(); idle(2);

        do_program(); type_code(36'h98765, 5); do_confirm(); idle(1);
        do_confirm();
        type_code(36'h4321, 4); do_confirm();
        type_code(36'h98765, 5); do_confirm(); idle(1);

        do_program(); type_code(36'h321, 3); do_confirm();
        do_program(); type_code(36'h123456789, 9); do_confirm();
        do_confirm();
        type_code(36'h98765, 5); do_confirm();
        do_program(); type_code(36'h21, 2);
        reset_pulse();
        idle(1);
        cycle(1'b1, 12, 1'b0, 1'b0);
        type_code(36'h54321, 5); do_confirm();
        type_code(36'h321, 3); cycle(1'b1, 4, 1'b1, 1'b0); idle(1);
        do_program(); type_code(36'h1, 1); idle(U + 3);

        for (int it = 0; it < 90; it++) begin
            r = $urandom_range(0, 6);
            case (r)
                0: type_model_pin(1'b0);
                1: type_model_pin(1'b1);
                2: begin type_random($urandom_range(1, 9)); do_confirm(); end
                3: begin
                    do_program();
                    type_random($urandom_range(2, 9));
                    if ($urandom_range(0, 3) != 0) do_confirm();
                end
                4: idle($urandom_range(0, 20));
                5: repeat ($urandom_range(1, 10))
                       cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
                default: if ($urandom_range(0, 1) != 0) do_confirm(); else do_program();
            endcase
        end
        idle(3);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
